// File: rtl/gpu_host_loader.sv
// Host front end for the 2x2 matrix-multiply GPU: streams operands into GPU memory, starts it, streams results out.
// Optional WAIT watchdog enabled by defining LOADER_TIMEOUT_EN.
module gpu_host_loader #(
  parameter int ADDR_W  = 4,
  parameter int A_BASE  = 0,
  parameter int C_BASE  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              gpu_start,
  input  logic              gpu_done,
  output logic              out_valid,
  output logic [15:0]       out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              timeout_err
);

  typedef enum logic [2:0] {
    ST_LOAD, ST_START, ST_WAIT, ST_RD_LO, ST_RD_HI, ST_RD_CAP, ST_OUT
  } state_t;

  localparam logic [ADDR_W-1:0] A_ADDR = ADDR_W'(A_BASE);
  localparam logic [ADDR_W-1:0] C_ADDR = ADDR_W'(C_BASE);

  state_t     state, next_state;
  logic [2:0] cnt;
  logic [1:0] k;
  logic [7:0] lo_byte;
  logic       accept;
  logic       handshake;

  assign accept    = (state == ST_LOAD) && in_valid;
  assign handshake = (state == ST_OUT) && out_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_expired;

  assign wait_expired = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_LOAD;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_LOAD:   if (accept && cnt == 3'd7) next_state = ST_START;
      ST_START:  next_state = ST_WAIT;
      ST_WAIT: begin
        if (gpu_done) next_state = ST_RD_LO;
`ifdef LOADER_TIMEOUT_EN
        else if (wait_expired) next_state = ST_LOAD;
`endif
      end
      ST_RD_LO:  next_state = ST_RD_HI;
      ST_RD_HI:  next_state = ST_RD_CAP;
      ST_RD_CAP: next_state = ST_OUT;
      ST_OUT:    if (handshake) next_state = (k == 2'd3) ? ST_LOAD : ST_RD_LO;
      default:   next_state = ST_LOAD;
    endcase
  end

  // Memory port is combinational so a LOAD byte is written in the cycle it is accepted
  always_comb begin
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          mem_we    = 1'b1;
          mem_addr  = A_ADDR + ADDR_W'(cnt);
          mem_wdata = in_data;
        end
      end
      ST_RD_LO: mem_addr = C_ADDR + ADDR_W'({k, 1'b0});
      ST_RD_HI: mem_addr = C_ADDR + ADDR_W'({k, 1'b1});
      default: ;
    endcase
  end

  // Registered outputs are derived from next_state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      k         <= '0;
      lo_byte   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      gpu_start <= 1'b0;
      busy      <= 1'b0;
    end else begin
      gpu_start <= (next_state == ST_START);
      out_valid <= (next_state == ST_OUT);
      busy      <= (next_state != ST_LOAD);
      if (accept) cnt <= (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
      if (state == ST_RD_HI)  lo_byte  <= mem_rdata;
      if (state == ST_RD_CAP) out_data <= {mem_rdata, lo_byte};
      if (handshake) k <= (k == 2'd3) ? 2'd0 : k + 2'd1;
    end
  end

`ifdef LOADER_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != ST_WAIT) wait_cnt <= '0;
      else                  wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_WAIT && !gpu_done && wait_expired) timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_gpu_host_loader.sv
// Directed bench for gpu_host_loader: byte-wide GPU memory model plus a GPU stub that multiplies 10 cycles after start.
module tb_gpu_host_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        gpu_start;
  logic        gpu_done = 1'b0;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        timeout_err;

  gpu_host_loader dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .gpu_start(gpu_start), .gpu_done(gpu_done),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ops;
    logic [63:0] words;
    bit          gaps;
    int          stall_idx;
  } vec_t;

  logic [7:0]  mem [16];
  logic [15:0] c_val;
  int          cyc = 0;
  int          done_cyc = 0;
  int          start_count = 0;
  int          stub_timer = 0;
  bit          stub_en = 1'b0;
  int          n_vectors = 0;
  int          n_miscompares = 0;

  // Synchronous-read memory and GPU stub: C = A*B (mod 2^16) written back, then done pulsed
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (gpu_start) start_count <= start_count + 1;
    if (gpu_done) done_cyc <= cyc + 1;
    mem_rdata <= mem[mem_addr];
    if (mem_we) mem[mem_addr] <= mem_wdata;
    gpu_done <= 1'b0;
    if (gpu_start && stub_en) stub_timer <= 10;
    else if (stub_timer != 0) begin
      stub_timer <= stub_timer - 1;
      if (stub_timer == 1) begin
        for (int i = 0; i < 2; i++) begin
          for (int j = 0; j < 2; j++) begin
            c_val = {8'h00, mem[2*i]} * {8'h00, mem[4+j]} + {8'h00, mem[2*i+1]} * {8'h00, mem[6+j]};
            mem[8+2*(2*i+j)] <= c_val[7:0];
            mem[9+2*(2*i+j)] <= c_val[15:8];
          end
        end
        gpu_done <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] ops, input bit gaps);
    for (int i = 0; i < 8; i++) begin
      if (gaps && i > 0) begin
        repeat (2) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_data  = 8'h00;
          #1 check("idle_we", {31'd0, mem_we}, 32'd0);
        end
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = ops[8*i +: 8];
      #1 check("load_bus", {in_ready, mem_we, mem_addr, mem_wdata}, {1'b1, 1'b1, 4'(i), ops[8*i +: 8]});
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 check("start_pulse", {gpu_start, busy, in_ready}, 3'b110);
  endtask

  task automatic checkOutput(input logic [63:0] words, input int stall_idx);
    int          c0;
    int          waited;
    logic [15:0] held;
    bit          stable;
    c0 = 0;
    for (int w = 0; w < 4; w++) begin
      waited = 0;
      while (!out_valid && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      if (!out_valid) begin
        n_vectors++;
        n_miscompares++;
        $display("[TB] FAIL valid_wait word%0d: out_valid low after %0d cycles, expected high", w, waited);
        return;
      end
      if (w == 0) check("done_to_valid", cyc, done_cyc + 3);
      else        check("word_gap", cyc, c0 + 4);
      check($sformatf("word%0d", w), {16'd0, out_data}, {16'd0, words[16*w +: 16]});
      if (w == stall_idx) begin
        held   = out_data;
        stable = 1'b1;
        repeat (5) begin
          @(negedge clk);
          if (!out_valid || out_data !== held) stable = 1'b0;
        end
        check("stall_hold", {31'd0, stable}, 32'd1);
      end
      c0 = cyc;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    #1 check("back_to_load", {busy, in_ready, out_valid}, 3'b010);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    vec_t vecs [4];
    int   s0;
    bit   busy_all;
    bit   saw_valid;

    vecs[0] = '{ops: 64'h0807060504030201, words: 64'h0032_002B_0016_0013, gaps: 1'b0, stall_idx: -1};
    vecs[1] = '{ops: 64'h0807060504030201, words: 64'h0032_002B_0016_0013, gaps: 1'b1, stall_idx: -1};
    vecs[2] = '{ops: 64'hFFFFFFFFFFFFFFFF, words: 64'hFC02_FC02_FC02_FC02, gaps: 1'b0, stall_idx: 2};
    vecs[3] = '{ops: 64'h03FF02FF01008080, words: 64'h0003_00FF_0280_FF00, gaps: 1'b1, stall_idx: 3};

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    stub_en   = 1'b1;
    #1;
    check("reset_ctl", {in_ready, mem_we, mem_addr, mem_wdata, gpu_start, busy, timeout_err},
          {1'b1, 1'b0, 4'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    check("reset_out", {out_valid, out_data}, 17'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int v = 0; v < 4; v++) begin
      $display("[TB] vector %0d ops=%h", v, vecs[v].ops);
      s0 = start_count;
      applyStimulus(vecs[v].ops, vecs[v].gaps);
      checkOutput(vecs[v].words, vecs[v].stall_idx);
      check("start_count", start_count - s0, 1);
      for (int i = 0; i < 8; i++) check("mem_byte", {24'd0, mem[i]}, {24'd0, vecs[v].ops[8*i +: 8]});
    end

    // Partial load abandoned by reset: next load must restart at address 0
    stub_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'hAA;
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Reset while waiting on the GPU
    applyStimulus(64'h0807060504030201, 1'b0);
    repeat (3) @(negedge clk);
    #1 check("wait_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1 check("reset_mid_wait", {busy, in_ready, out_valid, gpu_start}, 4'b0100);
    @(negedge clk);
    reset = 1'b0;

    stub_en = 1'b1;
    s0 = start_count;
    applyStimulus(64'h0, 1'b0);
    checkOutput(64'h0, -1);
    check("start_count", start_count - s0, 1);
    for (int i = 0; i < 8; i++) check("mem_zero", {24'd0, mem[i]}, 32'd0);

    // GPU never finishes
    stub_en   = 1'b0;
    saw_valid = 1'b0;
    busy_all  = 1'b1;
    applyStimulus(64'h0807060504030201, 1'b0);
`ifdef LOADER_TIMEOUT_EN
    repeat (64) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("pre_timeout", {busy, timeout_err}, 2'b10);
    @(negedge clk);
    check("timeout", {busy, in_ready, timeout_err, out_valid}, 4'b0110);
    check("no_valid", {31'd0, saw_valid}, 32'd0);
`else
    repeat (200) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
      if (!busy) busy_all = 1'b0;
    end
    check("busy_hold", {31'd0, busy_all}, 32'd1);
    check("no_valid", {31'd0, saw_valid}, 32'd0);
    check("no_timeout_err", {31'd0, timeout_err}, 32'd0);
`endif
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
